// File: rtl/mandelbrot_iteration_counter.sv
// mandelbrot_iteration_counter: up-counting per-pixel iteration tracker with buffered valid/ready result output.
// Define MANDELBROT_ITERCOUNT_SKID_EN for a 2-entry result FIFO; default is a single result register.
module mandelbrot_iteration_counter #(
  parameter int WIDTH = 11,
  parameter int TAG_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] max_iter,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [TAG_W-1:0] start_tag,
  input  logic             step,
  input  logic             escaped,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [TAG_W-1:0] res_tag,
  output logic [WIDTH-1:0] res_count,
  output logic             res_inset
);
  localparam int EW = TAG_W + WIDTH + 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] count, count_nx, max_lat, next, push_count;
  logic [TAG_W-1:0] tag_lat, push_tag;
  logic start_hs, push, push_inset, pop;
  logic [EW-1:0] push_ent;
  assign next = count + WIDTH'(1);
  assign start_hs = start_valid && start_ready;
  assign pop = res_valid && res_ready;
  assign busy = state == RUN;
  assign push_ent = {push_tag, push_count, push_inset};
  always_comb begin
    state_nx = state;
    count_nx = count;
    push = 1'b0;
    push_tag = tag_lat;
    push_count = next;
    push_inset = 1'b0;
    if (state == IDLE && start_hs) begin
      count_nx = '0;
      if (max_iter == '0) begin
        push = 1'b1;
        push_tag = start_tag;
        push_count = '0;
        push_inset = 1'b1;
      end else state_nx = RUN;
    end else if (state == RUN && step) begin
      // escape takes priority over reaching the limit on the same step
      if (escaped || next == max_lat) begin
        push = 1'b1;
        push_inset = !escaped;
        state_nx = IDLE;
      end else count_nx = next;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      max_lat <= '0;
      tag_lat <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      if (start_hs) begin
        tag_lat <= start_tag;
        max_lat <= max_iter;
      end
    end
  end
`ifdef MANDELBROT_ITERCOUNT_SKID_EN
  logic [1:0] occ, occ_nx;
  logic [EW-1:0] ent1;
  assign occ_nx = occ + 2'(push) - 2'(pop);
  assign start_ready = state == IDLE && occ != 2'd2;
  // head entry lives directly in the output registers; ent1 is the waiting one
  always_ff @(posedge clk) begin
    if (reset) begin
      occ <= '0;
      res_valid <= 1'b0;
      {res_tag, res_count, res_inset} <= '0;
      ent1 <= '0;
    end else begin
      occ <= occ_nx;
      res_valid <= occ_nx != 2'd0;
      if (pop) begin
        if (occ == 2'd2) begin
          {res_tag, res_count, res_inset} <= ent1;
          if (push) ent1 <= push_ent;
        end else if (push) {res_tag, res_count, res_inset} <= push_ent;
      end else if (push) begin
        if (occ == 2'd0) {res_tag, res_count, res_inset} <= push_ent;
        else ent1 <= push_ent;
      end
    end
  end
`else
  assign start_ready = state == IDLE && (!res_valid || res_ready);
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid <= 1'b0;
      {res_tag, res_count, res_inset} <= '0;
    end else if (push) begin
      res_valid <= 1'b1;
      {res_tag, res_count, res_inset} <= push_ent;
    end else if (pop) res_valid <= 1'b0;
  end
`endif
endmodule
